// File: rtl/scan_test_sequencer_if.sv
// Start/abort control, UART byte stream and CSoC test pins of the scan-test sequencer.
// master side drives requests, tx_ready_i and scan_out_i; slave side is the sequencer.
interface scan_test_sequencer_if;
  logic       start_i;
  logic       abort_i;
  logic       busy_o;
  logic       done_o;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;
  logic       scan_out_i;
  logic       csoc_clk;
  logic       csoc_rstn;
  logic       csoc_test_se;
  logic       csoc_test_tm;

  modport master (
    output start_i, abort_i, tx_ready_i, scan_out_i,
    input  busy_o, done_o, tx_valid_o, tx_data_o,
           csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm
  );

  modport slave (
    input  start_i, abort_i, tx_ready_i, scan_out_i,
    output busy_o, done_o, tx_valid_o, tx_data_o,
           csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm
  );
endinterface

// File: rtl/scan_test_sequencer.sv
// Scan-test sequencer: reset CSoC, shift chain out as 'H'/'L' bytes, run, shift again; outputs registered (1 cycle).
// A pending byte stalls the sequence: no csoc_clk edge until the UART accepts it.
module scan_test_sequencer #(
  parameter int NUM_REGS   = 20,
  parameter int RUN_TICKS  = 6,
  parameter int MAX_COL    = 8,
  parameter int RST_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  scan_test_sequencer_if.slave bus
);
  localparam int BW   = $clog2(NUM_REGS + 1);
  localparam int CW   = $clog2(MAX_COL + 1);
  localparam int TMAX = (RST_CYCLES > RUN_TICKS) ? RST_CYCLES : RUN_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [7:0] CH_H  = 8'h48;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_NL = 8'h0A;

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_SHIFT1, S_RUN, S_SHIFT2, S_DONE} state_e;
  typedef enum logic [2:0] {B_SAMPLE, B_SEND, B_CLK_H, B_CLK_L, B_NL} step_e;

  state_e        state_q, state_d;
  step_e         step_q, step_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d, bit_nx;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          cclk_q, cclk_d, rstn_q, rstn_d;
  logic          se_q, se_d, tm_q, tm_d;
  logic          end_phase;

  assign bit_nx = bit_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    bit_cnt_d  = bit_cnt_q;
    col_d      = col_q;
    tick_d     = tick_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cclk_d     = cclk_q;
    rstn_d     = rstn_q;
    se_d       = se_q;
    tm_d       = tm_q;
    end_phase  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d   = S_CRST;
          busy_d    = 1'b1;
          rstn_d    = 1'b0;
          tm_d      = 1'b1;
          tick_d    = '0;
          bit_cnt_d = '0;
          col_d     = '0;
        end
      end
      S_CRST: begin
        if (tick_q == TW'(RST_CYCLES - 1)) begin
          state_d = S_SHIFT1;
          step_d  = B_SAMPLE;
          rstn_d  = 1'b1;
          se_d    = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_SHIFT1, S_SHIFT2: begin
        case (step_q)
          B_SAMPLE: begin
            tx_data_d  = bus.scan_out_i ? CH_H : CH_L;
            tx_valid_d = 1'b1;
            step_d     = B_SEND;
          end
          B_SEND: begin
            if (bus.tx_ready_i) begin
              tx_valid_d = 1'b0;
              col_d      = col_q + 1'b1;
              cclk_d     = 1'b1;
              step_d     = B_CLK_H;
            end
          end
          B_CLK_H: begin
            cclk_d = 1'b0;
            step_d = B_CLK_L;
          end
          B_CLK_L: begin
            bit_cnt_d = bit_nx;
            // Full line, or a partial last line that still needs terminating.
            if (col_q == CW'(MAX_COL) || (bit_nx == BW'(NUM_REGS) && col_q != '0)) begin
              tx_data_d  = CH_NL;
              tx_valid_d = 1'b1;
              step_d     = B_NL;
            end else if (bit_nx < BW'(NUM_REGS)) begin
              step_d = B_SAMPLE;
            end else begin
              end_phase = 1'b1;
            end
          end
          B_NL: begin
            if (bus.tx_ready_i) begin
              tx_valid_d = 1'b0;
              col_d      = '0;
              if (bit_cnt_q < BW'(NUM_REGS)) step_d = B_SAMPLE;
              else                           end_phase = 1'b1;
            end
          end
          default: step_d = B_SAMPLE;
        endcase
      end
      S_RUN: begin
        // After the last pulse one extra low cycle passes before se rises again.
        if (!cclk_q) begin
          if (tick_q == TW'(RUN_TICKS)) begin
            state_d   = S_SHIFT2;
            step_d    = B_SAMPLE;
            se_d      = 1'b1;
            bit_cnt_d = '0;
            col_d     = '0;
          end else begin
            cclk_d = 1'b1;
          end
        end else begin
          cclk_d = 1'b0;
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        se_d    = 1'b0;
        tm_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_phase) begin
      se_d = 1'b0;
      if (state_q == S_SHIFT1) begin
        state_d = S_RUN;
        tick_d  = '0;
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (bus.abort_i) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      tx_valid_d = 1'b0;
      cclk_d     = 1'b0;
      se_d       = 1'b0;
      tm_d       = 1'b0;
      rstn_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= B_SAMPLE;
      bit_cnt_q  <= '0;
      col_q      <= '0;
      tick_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cclk_q     <= 1'b0;
      rstn_q     <= 1'b0;
      se_q       <= 1'b0;
      tm_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      bit_cnt_q  <= bit_cnt_d;
      col_q      <= col_d;
      tick_q     <= tick_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cclk_q     <= cclk_d;
      rstn_q     <= rstn_d;
      se_q       <= se_d;
      tm_q       <= tm_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.tx_valid_o   = tx_valid_q;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.csoc_clk     = cclk_q;
  assign bus.csoc_rstn    = rstn_q;
  assign bus.csoc_test_se = se_q;
  assign bus.csoc_test_tm = tm_q;
endmodule

// File: tb/tb_scan_test_sequencer.sv
// Bench for scan_test_sequencer: control-timing vector table, full runs against a byte-stream model,
// backpressure, abort, and a 16-register instance.
module tb_scan_test_sequencer;
  localparam int N  = 20;
  localparam int MC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_test_sequencer_if bus ();
  scan_test_sequencer_if bus16 ();

  scan_test_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  scan_test_sequencer #(.NUM_REGS(16)) u_d16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    bit rst, start, abort;
    bit busy, rstn, tm, se, vld, done, dchk;
    logic [7:0] dat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  bit pat [64];
  int rdy_pct = 0;
  logic [7:0] got[$];
  logic [7:0] got16[$];
  logic [7:0] exp_q[$];
  int shift_p = 0, run_p = 0, dones = 0, viol = 0, dones16 = 0;

  // Consumer: tx_ready_i high with probability rdy_pct percent.
  always @(posedge clk) begin
    #1;
    bus.tx_ready_i = ($urandom_range(0, 99) < rdy_pct);
  end

  // CSoC chain: one bit per shift pulse, counted across both phases of a sequence.
  int   sidx = 0;
  logic ch_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.busy_o !== 1'b1) sidx = 0;
    else if (bus.csoc_clk === 1'b1 && ch_prev !== 1'b1 && bus.csoc_test_se === 1'b1) sidx = sidx + 1;
    ch_prev = bus.csoc_clk;
    bus.scan_out_i = pat[sidx % 64];
  end

  logic p_clk = 1'b0, p_se = 1'b0, p_vld = 1'b0, p_rdy = 1'b0, p_abort = 1'b0, p_rst = 1'b1;
  logic [7:0] p_dat = 8'h00;
  always @(negedge clk) begin
    if (bus.tx_valid_o === 1'b1 && bus.tx_ready_i === 1'b1) got.push_back(bus.tx_data_o);
    if (bus.csoc_clk === 1'b1 && p_clk === 1'b0) begin
      if (bus.csoc_test_se === 1'b1) shift_p++;
      else run_p++;
    end
    if (bus.done_o === 1'b1) dones++;
    if (p_abort === 1'b0 && p_rst === 1'b0) begin
      if (p_vld && !p_rdy && (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== p_dat || bus.csoc_clk !== p_clk)) viol++;
      if (bus.csoc_test_se !== p_se && (bus.csoc_clk !== 1'b0 || p_clk !== 1'b0)) viol++;
      if (bus.csoc_clk === 1'b1 && p_clk === 1'b1) viol++;
      if (bus.csoc_clk === 1'b1 && bus.tx_valid_o === 1'b1) viol++;
    end
    p_clk = bus.csoc_clk; p_se = bus.csoc_test_se; p_vld = bus.tx_valid_o;
    p_rdy = bus.tx_ready_i; p_dat = bus.tx_data_o; p_abort = bus.abort_i; p_rst = rst;
  end

  always @(negedge clk) begin
    if (bus16.tx_valid_o === 1'b1 && bus16.tx_ready_i === 1'b1) got16.push_back(bus16.tx_data_o);
    if (bus16.done_o === 1'b1) dones16++;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Expected stream: each bit as 'H'/'L', newline after every MC bits and after the last bit of a phase.
  task automatic build_exp(input int n, input bit use_pat);
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++)
      for (int b = 0; b < n; b++) begin
        exp_q.push_back((use_pat ? pat[ph * n + b] : 1'b1) ? 8'h48 : 8'h4C);
        if ((b + 1) % MC == 0 || b == n - 1) exp_q.push_back(8'h0A);
      end
  endtask

  task automatic cmp_stream(input string nm, input logic [7:0] act[$], input int base);
    int errs;
    errs = 0;
    check({nm, " byte count"}, act.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= act.size() || act[base + i] !== exp_q[i]) errs++;
    check({nm, " mismatched bytes"}, errs, 0);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic do_run(input string nm, input int pct, input bit xs);
    int base, sp0, rp0, d0, v0, cyc;
    bit sent;
    base = got.size(); sp0 = shift_p; rp0 = run_p; d0 = dones; v0 = viol;
    cyc = 0; sent = 1'b0;
    rdy_pct = pct;
    build_exp(N, 1'b1);
    pulse_start();
    while (dones == d0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.start_i) bus.start_i = 1'b0;
      else if (xs && !sent && shift_p - sp0 >= 3) begin
        bus.start_i = 1'b1;
        sent = 1'b1;
      end
    end
    bus.start_i = 1'b0;
    check({nm, " completed in budget"}, (cyc < 20000) ? 1 : 0, 1);
    chk1({nm, " idle after done"}, bus.busy_o, 1'b0);
    cmp_stream(nm, got, base);
    check({nm, " shift pulses"}, shift_p - sp0, 2 * N);
    check({nm, " run pulses"}, run_p - rp0, 6);
    check({nm, " done pulses"}, dones - d0, 1);
    check({nm, " protocol violations"}, viol - v0, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [12];
    int cyc, sp0, d0, nn;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    bus16.start_i = 1'b0; bus16.abort_i = 1'b0; bus16.tx_ready_i = 1'b1; bus16.scan_out_i = 1'b1;
    for (int k = 0; k < 64; k++) pat[k] = 1'b1;
    //          rst st ab  busy rstn tm se vld done dchk dat
    vt[0]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 8'h00};
    vt[1]  = '{0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 8'h00};
    vt[2]  = '{0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 8'h00};
    vt[3]  = '{0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00};
    vt[4]  = '{0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00};
    vt[5]  = '{0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00};
    vt[6]  = '{0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 8'h00};
    vt[7]  = '{0, 0, 0,  1, 1, 1, 1, 0, 0, 0, 8'h00};
    vt[8]  = '{0, 0, 0,  1, 1, 1, 1, 1, 0, 1, 8'h48};
    vt[9]  = '{0, 1, 0,  1, 1, 1, 1, 1, 0, 1, 8'h48};
    vt[10] = '{0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 8'h00};
    vt[11] = '{0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; bus.start_i = vt[i].start; bus.abort_i = vt[i].abort;
      @(posedge clk); #1;
      chk1($sformatf("vec%0d busy", i), bus.busy_o, vt[i].busy);
      chk1($sformatf("vec%0d csoc_rstn", i), bus.csoc_rstn, vt[i].rstn);
      chk1($sformatf("vec%0d tm", i), bus.csoc_test_tm, vt[i].tm);
      chk1($sformatf("vec%0d se", i), bus.csoc_test_se, vt[i].se);
      chk1($sformatf("vec%0d tx_valid", i), bus.tx_valid_o, vt[i].vld);
      chk1($sformatf("vec%0d done", i), bus.done_o, vt[i].done);
      chk1($sformatf("vec%0d csoc_clk", i), bus.csoc_clk, 1'b0);
      if (vt[i].dchk) chk8($sformatf("vec%0d tx_data", i), bus.tx_data_o, vt[i].dat);
    end
    rst = 1'b0; bus.start_i = 1'b0; bus.abort_i = 1'b0;

    // Synchronous reset in the middle of SHIFT1.
    rdy_pct = 100; sp0 = shift_p; cyc = 0;
    pulse_start();
    while (shift_p - sp0 < 3 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    check("reset reached SHIFT1", (cyc < 2000) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("rst busy", bus.busy_o, 1'b0);
    chk1("rst done", bus.done_o, 1'b0);
    chk1("rst tx_valid", bus.tx_valid_o, 1'b0);
    chk8("rst tx_data", bus.tx_data_o, 8'h00);
    chk1("rst csoc_clk", bus.csoc_clk, 1'b0);
    chk1("rst csoc_rstn", bus.csoc_rstn, 1'b0);
    chk1("rst se", bus.csoc_test_se, 1'b0);
    chk1("rst tm", bus.csoc_test_tm, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    do_run("all ones", 100, 1'b0);
    for (int k = 0; k < 64; k++) pat[k] = (k % 2 == 1);
    do_run("alternating", 100, 1'b0);
    for (int k = 0; k < 64; k++) pat[k] = ($urandom_range(0, 1) == 1);
    do_run("random ready", 100, 1'b0);
    do_run("random backpressure", 30, 1'b0);
    for (int k = 0; k < 64; k++) pat[k] = 1'b1;
    do_run("start while busy", 100, 1'b1);

    // Abort at bit 5 of SHIFT2 with that byte still pending.
    rdy_pct = 100; sp0 = shift_p; d0 = dones; cyc = 0;
    pulse_start();
    while (shift_p - sp0 < 25 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    rdy_pct = 0;
    while (bus.tx_valid_o !== 1'b1 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    check("abort point reached", (cyc < 5000) ? 1 : 0, 1);
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    chk1("abort busy", bus.busy_o, 1'b0);
    chk1("abort tx_valid", bus.tx_valid_o, 1'b0);
    chk1("abort csoc_clk", bus.csoc_clk, 1'b0);
    chk1("abort se", bus.csoc_test_se, 1'b0);
    chk1("abort tm", bus.csoc_test_tm, 1'b0);
    chk1("abort csoc_rstn", bus.csoc_rstn, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("abort no done", dones - d0, 0);
    chk1("abort stays idle", bus.busy_o, 1'b0);
    do_run("after abort", 100, 1'b0);

    // Chain length an exact multiple of the line width.
    bus16.start_i = 1'b1;
    @(posedge clk); #1;
    bus16.start_i = 1'b0;
    cyc = 0;
    while (dones16 == 0 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    check("len16 completed in budget", (cyc < 5000) ? 1 : 0, 1);
    build_exp(16, 1'b0);
    cmp_stream("len16", got16, 0);
    nn = 0;
    for (int i = 1; i < got16.size(); i++)
      if (got16[i] == 8'h0A && got16[i - 1] == 8'h0A) nn++;
    check("len16 empty lines", nn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
